// File: rtl/jtkicker_irqctl.sv
// Interrupt controller with per-channel edge triggers, event dividers and an
// optional frame watchdog.
module jtkicker_irqctl #(
  parameter int CH    = 2,
  parameter int DIVW  = 4,
  parameter int WDW   = 4,
  parameter int WDLEN = 8,
  parameter int WDEN  = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen,
  input  logic [CH-1:0] trig,
  input  logic          en_we,
  input  logic          ack_we,
  input  logic          div_we,
  input  logic [1:0]    div_sel,
  input  logic [7:0]    din,
  input  logic          wdog_kick,
  input  logic          vb,
  output logic [CH-1:0] irq_n,
  output logic [CH-1:0] pend,
  output logic          wdog_rst
);

  logic [CH-1:0]   trig_q;
  logic [CH-1:0]   trig_e;
  logic            vb_q;
  logic            vb_e;
  logic [CH-1:0]   en;
  logic [CH-1:0]   pend_r;
  logic [DIVW-1:0] div [CH];
  logic [DIVW-1:0] cnt [CH];
  logic            en_wr;
  logic            ack_wr;
  logic            div_wr;
  logic            unused_bits;

  assign en_wr  = cen & en_we;
  assign ack_wr = cen & ack_we;
  assign div_wr = cen & div_we;

  // Copies reset high so inputs already high at release give no edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trig_q <= '1;
      vb_q   <= 1'b1;
    end else begin
      trig_q <= trig;
      vb_q   <= vb;
    end
  end

  assign trig_e = trig & ~trig_q;
  assign vb_e   = vb & ~vb_q;

  // Edge qualification uses the pre-write en; a disable write overrides everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en     <= '0;
      pend_r <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        div[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (en_wr) en <= din[CH-1:0];
      for (int unsigned i = 0; i < CH; i++) begin
        if (div_wr && div_sel == 2'(i)) div[i] <= din[DIVW-1:0];
        if (!en[i] || (en_wr && !din[i])) begin
          pend_r[i] <= 1'b0;
          cnt[i]    <= '0;
        end else begin
          if (trig_e[i] && cnt[i] == div[i]) pend_r[i] <= 1'b1;
          else if (ack_wr && din[i])          pend_r[i] <= 1'b0;
          if (div_wr && div_sel == 2'(i)) cnt[i] <= '0;
          else if (trig_e[i])             cnt[i] <= (cnt[i] == div[i]) ? '0 : cnt[i] + DIVW'(1);
        end
      end
    end
  end

  assign pend  = pend_r;
  assign irq_n = ~pend_r;

  generate
    if (WDEN != 0) begin : g_wd
      logic [WDW-1:0] wd;
      logic           wd_pulse;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wd       <= '0;
          wd_pulse <= 1'b0;
        end else begin
          wd_pulse <= 1'b0;
          if (cen && wdog_kick) begin
            wd <= '0;
          end else if (vb_e) begin
            if (wd + WDW'(1) == WDW'(WDLEN)) begin
              wd       <= '0;
              wd_pulse <= 1'b1;
            end else begin
              wd <= wd + WDW'(1);
            end
          end
        end
      end

      assign wdog_rst = wd_pulse;
    end else begin : g_nowd
      assign wdog_rst = 1'b0;
    end
  endgenerate

  assign unused_bits = ^{din, vb_e, wdog_kick};

endmodule

// File: doc/jtkicker_irqctl.md
JTKICKER_IRQCTL -- requirements
Module: jtkicker_irqctl

Interface
REQ-001 The block SHALL have parameter CH, default 2, giving the number of interrupt channels (1..4).
REQ-002 The block SHALL have parameter DIVW, default 4, giving the per-channel event-divider width.
REQ-003 The block SHALL have parameter WDW, default 4, giving the watchdog frame-counter width.
REQ-004 The block SHALL have parameter WDLEN, default 8, giving the watchdog timeout in frames (1..2^WDW-1).
REQ-005 The block SHALL have parameter WDEN, default 1; a value of 0 disables the watchdog.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock (24 MHz).
REQ-007 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port cen, input, 1 bit: CPU bus clock enable; register writes take effect only on clk edges with cen=1.
REQ-009 The block SHALL have port trig, input, CH bits: per-channel trigger; rising-edge sensitive (e.g. ~LVBL, V16).
REQ-010 The block SHALL have port en_we, input, 1 bit: write strobe for the enable mask.
REQ-011 The block SHALL have port ack_we, input, 1 bit: write strobe for the pending-acknowledge mask.
REQ-012 The block SHALL have port div_we, input, 1 bit: write strobe for a divider value.
REQ-013 The block SHALL have port div_sel, input, 2 bits: selects the channel targeted by div_we.
REQ-014 The block SHALL have port din, input, 8 bits: CPU write data.
REQ-015 The block SHALL have port wdog_kick, input, 1 bit: watchdog restart strobe.
REQ-016 The block SHALL have port vb, input, 1 bit: frame tick for the watchdog; rising-edge sensitive.
REQ-017 The block SHALL have port irq_n, output, CH bits: active-low interrupt request per channel.
REQ-018 The block SHALL have port pend, output, CH bits: pending status for readback.
REQ-019 The block SHALL have port wdog_rst, output, 1 bit: one-clk high pulse on watchdog timeout.

Function
REQ-020 Edge detection SHALL register trig and vb on every clk, independent of cen; edge = input & ~registered copy.
REQ-021 On an edge of trig[i] with en[i]=1, if cnt[i]==div[i], the block SHALL set pend[i] and clear cnt[i]; otherwise it SHALL increment cnt[i].
REQ-022 A div[i] value of 0 SHALL raise pend[i] on every edge; a value of N SHALL raise it on every (N+1)th edge.
REQ-023 cen & en_we SHALL load en <= din[CH-1:0]; any channel written to 0 SHALL clear pend and cnt in that same clk, overriding a simultaneous edge.
REQ-024 An edge coincident with an en write SHALL be evaluated against the pre-write en value, so a 0->1 enable never latches that edge.
REQ-025 While en[i]=0, pend[i] and cnt[i] SHALL hold 0.
REQ-026 cen & ack_we SHALL clear pend[i] for each din[i]=1 without changing en or cnt; a coincident set event SHALL win, so the event is never lost.
REQ-027 cen & div_we SHALL load div[div_sel] <= din[DIVW-1:0] and clear cnt[div_sel]; a div_sel value >= CH SHALL be ignored.
REQ-028 irq_n SHALL equal ~pend, registered, with 1-clk latency from the causing edge or write; pend SHALL expose the same register.
REQ-029 Watchdog (WDEN=1): each vb edge SHALL increment wd; when the increment would reach WDLEN, wd SHALL instead be cleared and wdog_rst pulsed high for exactly one clk.
REQ-030 cen & wdog_kick SHALL clear wd; a kick coincident with a vb edge SHALL win, with no increment and no pulse.
REQ-031 With WDEN=0, wdog_rst SHALL be constant 0 and wd SHALL be unused.

Reset
REQ-032 rstn=0 SHALL asynchronously force en, div, cnt, pend and wd to 0, irq_n to all ones, and wdog_rst to 0.
REQ-033 rstn=0 SHALL force the registered trig and vb copies to all ones, so inputs already high at release produce no edge.
REQ-034 Reset asserted mid-operation SHALL drop a pending request within the same clk, with no glitch held after release.

Verification
REQ-035 Basic IRQ: CH=2, write en=0x01, pulse trig[0] -> irq_n=2'b10 one clk later; ack_we din=0x01 -> irq_n=2'b11.
REQ-036 Divider: div_sel=1, din=3, en=0x02, 8 edges on trig[1] -> pend[1] sets on edges 4 and 8 only (ack after each).
REQ-037 Simultaneous events: ack_we coincident with a trig[0] edge, en[0]=1, div=0 -> pend[0] stays 1.
REQ-038 Enable race: en write 0x00 coincident with a trig[0] edge -> pend[0]=0; en write 0x01 coincident with an edge -> pend[0]=0.
REQ-039 Watchdog: WDLEN=8, 8 vb edges with no kick -> single wdog_rst pulse on the 8th edge, wd=0; kick on the 7th edge -> no pulse.
REQ-040 Reset: trig=2'b11 and pend=2'b11 when rstn falls -> irq_n=2'b11 immediately; after release with trig held high and en=0x03 -> no interrupt.
